// File: rtl/mem_chk_pkg.sv
// Shared types and limits for the memory scoreboard checker.
// Pipeline entries are sized for the widest supported configuration.
package mem_chk_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 8;
   localparam int ERR_CNT_W  = 16;

   localparam int ENT_AW_MAX = 32;
   localparam int ENT_DW_MAX = 256;
   localparam int ENT_NB_MAX = ENT_DW_MAX / 8;

   typedef struct packed {
      logic                  valid;
      logic [ENT_AW_MAX-1:0] addr;
      logic [ENT_DW_MAX-1:0] exp;
      logic [ENT_NB_MAX-1:0] mask;
   } rd_entry_t;

   localparam int ENT_W = $bits(rd_entry_t);

endpackage

// File: rtl/mem_chk_rd_pipe.sv
// RD_LAT-deep delay line of read snapshots. The valid bit is the MSB of an
// entry and is the only part cleared by reset; payload just follows along.
module mem_chk_rd_pipe
   import mem_chk_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ENT_W-1:0] ent_in,
   output logic [ENT_W-1:0] ent_out
);

   logic [RD_LAT-1:0] vld_p;
   logic [ENT_W-2:0]  pay_p [RD_LAT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= ent_in[ENT_W-1];
         for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pay_p[0] <= ent_in[ENT_W-2:0];
      for (int i = 1; i < RD_LAT; i++) pay_p[i] <= pay_p[i-1];
   end

   assign ent_out = {vld_p[RD_LAT-1], pay_p[RD_LAT-1]};

endmodule

// File: rtl/mem_scoreboard_checker.sv
// Shadow-memory scoreboard: snapshots expected data at read request and
// checks the returned data RD_LAT cycles later, flagging and counting errors.
module mem_scoreboard_checker
   import mem_chk_pkg::*;
#(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic                 read,
   input  logic [AW-1:0]        addr,
   input  logic [DW-1:0]        wdata,
   input  logic [DW/8-1:0]      wbe,
   input  logic                 rvalid,
   input  logic [DW-1:0]        rdata,
   input  logic                 clr_err,
   output logic                 err_mismatch,
   output logic                 err_uninit,
   output logic                 err_missing,
   output logic                 err_unexp,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 first_err_valid,
   output logic [AW-1:0]        first_err_addr,
   output logic [DW-1:0]        first_err_exp,
   output logic [DW-1:0]        first_err_got
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 2 ** AW;

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || AW > ENT_AW_MAX ||
       DW > ENT_DW_MAX || (DW % 8) != 0) begin : g_param_err
      $error("mem_scoreboard_checker: unsupported parameter set");
   end

   function automatic logic [DW-1:0] lane_expand(input logic [NB-1:0] m);
      logic [DW-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) r[b*8 +: 8] = {8{m[b]}};
      return r;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   logic [DW-1:0] shadow  [DEPTH];
   logic [NB-1:0] written [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) written[i] <= '0;
      end else if (write) begin
         written[addr] <= written[addr] | wbe;
      end
   end

   always_ff @(posedge clk) begin
      if (write) begin
         for (int b = 0; b < NB; b++)
            if (wbe[b]) shadow[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

   // Snapshot stage: shadow is read before this edge's write lands.
   rd_entry_t snap, cmp;

   always_comb begin
      snap       = '0;
      snap.valid = read;
      snap.addr  = ENT_AW_MAX'(addr);
      snap.exp   = ENT_DW_MAX'(shadow[addr]);
      snap.mask  = ENT_NB_MAX'(written[addr]);
   end

   mem_chk_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .ent_in  (snap),
      .ent_out (cmp)
   );

   // Compare stage: entry leaving the delay line meets rvalid/rdata.
   logic [DW-1:0] exp_c;
   logic [NB-1:0] mask_c;
   logic          hit_c, miss_c, unexp_c, uninit_c, mism_c, any_c;

   always_comb begin
      exp_c    = DW'(cmp.exp);
      mask_c   = NB'(cmp.mask);
      hit_c    = cmp.valid & rvalid;
      miss_c   = cmp.valid & ~rvalid;
      unexp_c  = ~cmp.valid & rvalid;
      uninit_c = hit_c & (mask_c == '0);
      mism_c   = hit_c & (mask_c != '0) & (|((rdata ^ exp_c) & lane_expand(mask_c)));
      any_c    = miss_c | unexp_c | uninit_c | mism_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_mismatch    <= 1'b0;
         err_uninit      <= 1'b0;
         err_missing     <= 1'b0;
         err_unexp       <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         first_err_exp   <= '0;
         first_err_got   <= '0;
      end else begin
         err_mismatch <= mism_c;
         err_uninit   <= uninit_c;
         err_missing  <= miss_c;
         err_unexp    <= unexp_c;

         if (clr_err)    err_count <= any_c ? ERR_CNT_W'(1) : '0;
         else if (any_c) err_count <= sat_inc(err_count);

         // A clear in the same cycle as an error frees the capture for it.
         if (any_c && (clr_err || !first_err_valid)) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= unexp_c ? '0 : AW'(cmp.addr);
            first_err_exp   <= unexp_c ? '0 : exp_c;
            first_err_got   <= miss_c  ? '0 : rdata;
         end else if (clr_err) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
         end
      end
   end

endmodule
